// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared widths, lap limit, record layout and BCD unit positions used by the
// stopwatch lap-record path.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int REC_W   = 32;  // 4 units x 2 BCD digits x 4 bits
  localparam int IDX_W   = 7;   // lap number field, holds 0..99
  localparam int LAP_MAX = 99;  // lap numbering wraps from 99 back to 1

  // Byte position of each BCD unit inside a flattened record
  localparam int HOUR   = 3;
  localparam int MINUTE = 2;
  localparam int SECOND = 1;
  localparam int M_SEC  = 0;

  // Layout of one stored entry: {lap_idx, hour, minute, second, m_sec}
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       hour;
    logic [7:0]       minute;
    logic [7:0]       second;
    logic [7:0]       m_sec;
  } lap_rec_t;

  // Extract one BCD unit (two digits) from a flattened record
  function automatic logic [7:0] rec_unit(input logic [REC_W-1:0] rec, input int unit);
    return rec[unit*8 +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lap_counter_bcd.sv
// ---------------------------------------------------------------------------
// lap_counter_bcd
// Lap number generator: counts 1..LAP_MAX and wraps back to 1. next_idx_o
// is the number the next accepted lap will receive; inc_i commits it.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lap_counter_bcd #(
  parameter int IDX_W   = stopwatch_pkg::IDX_W,
  parameter int LAP_MAX = stopwatch_pkg::LAP_MAX
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] next_idx_o
);

  logic [IDX_W-1:0] lap_q;
  logic [IDX_W-1:0] lap_d;

  // Lap 0 means "no lap yet"; after LAP_MAX numbering restarts at 1, not 0
  assign next_idx_o = (lap_q < IDX_W'(LAP_MAX)) ? lap_q + 1'b1 : IDX_W'(1);

  // Next-state: clear wins over an increment in the same cycle
  always_comb begin
    lap_d = lap_q;
    if (clear_i) begin
      lap_d = '0;
    end else if (inc_i) begin
      lap_d = next_idx_o;
    end
  end

  // Lap counter register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lap_record_fifo.sv
// ---------------------------------------------------------------------------
// lap_record_fifo
// First-word fall-through buffer of lap timestamps between the stopwatch
// timer and the LCD bridge. Each record is tagged with a lap number.
// Build option: OVERWRITE_OLDEST_EN - when defined, a push into a full
// buffer evicts the oldest entry instead of dropping the new lap.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lap_record_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = stopwatch_pkg::REC_W,
  parameter int IDX_W = stopwatch_pkg::IDX_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [REC_W-1:0]           push_data,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [IDX_W+REC_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  import stopwatch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + REC_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             accept;
  logic             drop_oldest;
  logic             reject;
  logic [IDX_W-1:0] next_idx;

  // Head is visible straight from storage; it only moves on a pop, so it
  // holds steady while the consumer stalls
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;

  assign pop = out_valid & out_ready;

`ifdef OVERWRITE_OLDEST_EN
  // Every push is kept; a push into a full buffer without a pop evicts the head
  assign accept      = push;
  assign drop_oldest = push & full & ~pop;
  assign reject      = 1'b0;
`else
  // A pop in the same cycle frees a slot, so a full buffer can still accept
  assign accept      = push & (~full | pop);
  assign drop_oldest = 1'b0;
  assign reject      = push & full & ~pop;
`endif

  lap_counter_bcd #(
    .IDX_W   (IDX_W),
    .LAP_MAX (LAP_MAX)
  ) u_lap_counter (
    .clock_i    (clock),
    .reset_i    (reset),
    .clear_i    (clear),
    .inc_i      (accept),
    .next_idx_o (next_idx)
  );

  // Pointer, occupancy and overflow next-state; clear discards everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop | drop_oldest) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // An eviction is a write plus a discard, so occupancy stays put
      case ({accept & ~drop_oldest, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (reject | drop_oldest) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents are don't-care after reset since count gates them
  always_ff @(posedge clock) begin
    if (accept && !clear && !reset) begin
      mem_q[wr_ptr_q] <= {next_idx, push_data};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lap_record_fifo.sv
// ---------------------------------------------------------------------------
// tb_lap_record_fifo
// Directed bench for lap_record_fifo with a queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
// Build option: OVERWRITE_OLDEST_EN selects the eviction scenario.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lap_record_fifo;

  localparam int DEPTH = 4;
  localparam int REC_W = 32;
  localparam int IDX_W = 7;
  localparam int ENT_W = IDX_W + REC_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             push      = 1'b0;
  logic [REC_W-1:0] push_data = '0;
  logic             clear     = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [ENT_W-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  lap_record_fifo #(
    .DEPTH (DEPTH),
    .REC_W (REC_W),
    .IDX_W (IDX_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .clear     (clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: an ordered list of tagged laps --------
  logic [ENT_W-1:0] mq[$];
  int               m_lap  = 0;
  bit               m_ovf  = 1'b0;
  bit               m_live = 1'b0;

  function automatic int lap_after(input int lap);
    return (lap >= 99) ? 1 : lap + 1;
  endfunction

  always @(posedge clock) begin
    if (reset || clear) begin
      mq.delete();
      m_lap = 0;
      m_ovf = 1'b0;
      if (reset) m_live = 1'b1;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) begin
          m_lap = lap_after(m_lap);
          mq.push_back({IDX_W'(m_lap), push_data});
        end else begin
`ifdef OVERWRITE_OLDEST_EN
          void'(mq.pop_front());
          m_lap = lap_after(m_lap);
          mq.push_back({IDX_W'(m_lap), push_data});
`endif
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model on the falling edge, away from updates
  always @(negedge clock) begin
    if (m_live) begin
      chk("model_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("model_data", out_data, mq[0]);
      chk("model_count", count, mq.size());
      chk("model_full", full, mq.size() == DEPTH);
      chk("model_empty", empty, mq.size() == 0);
      chk("model_overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic p, input logic [REC_W-1:0] d, input logic c, input logic r);
    push      = p;
    push_data = d;
    clear     = c;
    out_ready = r;
    @(posedge clock);
    #1;
    push  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: single push becomes visible one cycle later with lap 1
    do_reset();
    cyc(1'b1, 32'h00012345, 1'b0, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, {7'd1, 32'h00012345});
    chk("t1_count", count, 1);

    // 2: fill, overflow by one, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h00000010 + i, 1'b0, 1'b0);
    chk("t2_full4", full, 1'b1);
    chk("t2_ovf4", overflow, 1'b0);
    cyc(1'b1, 32'h00000099, 1'b0, 1'b0);
    chk("t2_ovf5", overflow, 1'b1);
    chk("t2_count5", count, 4);
`ifndef OVERWRITE_OLDEST_EN
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_idx", out_data[ENT_W-1:REC_W], k);
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("t2_empty", empty, 1'b1);
    cyc(1'b1, 32'h00000077, 1'b0, 1'b0);
    chk("t2_next_idx", out_data, {7'd5, 32'h00000077});
`endif

    // 3: push and pop together while full
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h00001000 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'h00001005, 1'b0, 1'b1);
    chk("t3_count", count, 4);
    chk("t3_head_idx", out_data[ENT_W-1:REC_W], 2);
    chk("t3_overflow", overflow, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      chk("t3_drain_idx", out_data[ENT_W-1:REC_W], k);
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("t3_empty", empty, 1'b1);

    // 4: clear beats simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'h00002000 + i, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t4_count3", count, 3);
    chk("t4_ovf_before", overflow, 1'b1);
    cyc(1'b1, 32'h00002222, 1'b1, 1'b1);
    chk("t4_count0", count, 0);
    chk("t4_valid0", out_valid, 1'b0);
    chk("t4_ovf0", overflow, 1'b0);
    cyc(1'b1, 32'h00002333, 1'b0, 1'b0);
    chk("t4_restart_idx", out_data, {7'd1, 32'h00002333});

    // 5: 100 laps streamed through; numbering wraps 99 -> 1
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 32'(i), 1'b0, 1'b1);
      chk("t5_idx", out_data[ENT_W-1:REC_W], (i <= 99) ? i : 1);
      chk("t5_count", count, 1);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t5_empty", empty, 1'b1);

`ifdef OVERWRITE_OLDEST_EN
    // 6: overwrite mode evicts the oldest lap
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'h00003000 + i, 1'b0, 1'b0);
    chk("t6_overflow", overflow, 1'b1);
    chk("t6_count", count, 4);
    for (int k = 2; k <= 5; k++) begin
      chk("t6_drain_idx", out_data[ENT_W-1:REC_W], k);
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("t6_empty", empty, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lap_record_fifo.md
Name: lap_record_fifo

Overview:
Buffers lap timestamps between the stopwatch timer and the LCD bridge, so lap presses are not lost while the LCD is busy redrawing.
- Accepts flattened BCD timestamp records (hour, minute, second, m_sec; 8 bits each) on a push strobe from the key FSM.
- Tags each record with a lap number and presents records in order through a valid/ready handshake; the LCD bridge consumes them when not busy.
- A clear strobe flushes the buffer and restarts lap numbering.

Parameters:
DEPTH, 4, number of stored records; power of two, 2..16
REC_W, 32, record width in bits (4 units x 2 BCD digits x 4 bits)
IDX_W, 7, lap-number field width; holds 0..99

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
push  input  1  one-cycle strobe; store push_data
push_data  input  REC_W  BCD timestamp record
clear  input  1  one-cycle strobe; flush all records and lap numbering
out_ready  input  1  consumer can accept (driven as ~lcd_busy)
out_valid  output  1  head record available
out_data  output  IDX_W+REC_W  {lap_idx, record} of head entry
count  output  $clog2(DEPTH)+1  number of stored records
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; a push was dropped

Behaviour:
- Storage: circular buffer of DEPTH entries; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally; count is held separately.
- Reset: wr_ptr=rd_ptr=0, count=0, lap counter=0, overflow=0. Therefore out_valid=0, empty=1, full=0. Storage contents are don't-care.
- Output is first-word fall-through: out_valid = (count!=0); out_data reflects mem[rd_ptr] combinationally from registered state.
- Pop: occurs on a cycle where out_valid & out_ready. rd_ptr increments and count decrements at the next edge.
- Accepted push: occurs when push & (!full | pop).
  - Writes {next_idx, push_data} at wr_ptr; wr_ptr increments.
  - next_idx = lap counter + 1 when counter < 99, else 1. The lap counter is updated to next_idx.
- Rejected push (push & full & !pop): record discarded; lap counter unchanged; overflow <= 1.
- Simultaneous push and pop: both take effect, count unchanged. This holds when full, since the pop frees a slot in the same cycle.
- Pop when empty: impossible because out_valid=0; out_ready is ignored.
- Push when empty: the record becomes visible on out_valid one cycle later, giving push-to-valid latency of 1.
- Clear: has priority over push and pop in the same cycle. Pointers, count, lap counter and overflow all return to 0, and any push that cycle is discarded.
- Reset has priority over clear. Reset mid-transfer drops all contents with no partial records.
- out_data must stay stable while out_valid & !out_ready.

Optional Feature:
OVERWRITE_OLDEST_EN
- Defined: a push when full (without pop) is accepted. The oldest entry is discarded: rd_ptr and wr_ptr both advance and count stays DEPTH. The lap counter increments and overflow is set to 1.
- Undefined: rejection behaviour as above (newest lap dropped).

Decomposition:
- Shared package stopwatch_pkg holds:
  - REC_W, IDX_W, LAP_MAX=99
  - typedef lap_rec_t {idx, hour, minute, second, m_sec}
  - the unit index constants HOUR/MINUTE/SECOND/M_SEC
- One natural sub-module: lap_counter_bcd, the 1..99 wrapping lap counter with clear. Pointer/storage logic stays in the top.

Test Plan:
1. After reset, push 32'h00_01_23_45 (consumer not ready) -> next cycle out_valid=1, out_data={7'd1,32'h00012345}, count=1.
2. With DEPTH=4 and out_ready=0, push 5 records -> full=1 after 4th; 5th dropped, overflow=1, lap idx stays 4. Then out_ready=1 -> idx 1,2,3,4 in order, then empty=1.
3. Full buffer with push and out_ready=1 in the same cycle -> count stays 4, head idx 1->2, new tail idx 5, overflow=0.
4. Clear asserted together with push and pop, count=3 -> next cycle count=0, out_valid=0, overflow=0. The next push gets idx 1.
5. 100 pushes with continuous out_ready=1 -> idx sequence 1..99, then 1. Count never exceeds 1.
6. With OVERWRITE_OLDEST_EN defined, 5 pushes into DEPTH=4 with no pops -> drained idx 2,3,4,5; overflow=1.
